// File: rtl/mem_store_buffer.sv
// mem_store_buffer: in-order store FIFO sharing one data-SRAM port with loads (st_* in, ld_* probe, data_sram_* port, misalign pulse, sb_count)
module mem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [2:0]               st_op,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic                     ld_req,
    input  logic [31:0]              ld_addr,
    output logic                     ld_conflict,
    output logic                     data_sram_en,
    output logic [3:0]               data_sram_wen,
    output logic [31:0]              data_sram_addr,
    output logic [31:0]              data_sram_wdata,
    output logic                     misalign,
    output logic [$clog2(DEPTH):0]   sb_count
);
    localparam int AW = $clog2(DEPTH);
    logic [3:0]    e_wen  [DEPTH];
    logic [29:0]   e_word [DEPTH];
    logic [31:0]   e_data [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [AW:0]   count;
    logic          is_sw, is_sh, is_sb, mis, acc, push, pop, ld_go, hit;
    logic [3:0]    a_wen;
    logic [31:0]   a_data;
    assign is_sw    = st_op == 3'b001;
    assign is_sh    = st_op == 3'b010;
    assign is_sb    = st_op == 3'b100;
    assign mis      = (is_sh & st_addr[0]) | (is_sw & |st_addr[1:0]);
    assign st_ready = reset | (count != (AW+1)'(DEPTH));
    assign acc      = st_valid & st_ready & !reset;
    assign push     = acc & (is_sw | is_sh | is_sb) & !mis;
    assign a_wen    = is_sw ? 4'b1111 : is_sh ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << st_addr[1:0];
    assign a_data   = is_sw ? st_data : is_sh ? {2{st_data[15:0]}} : {4{st_data[7:0]}};
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            hit = hit | (({1'b0, AW'(AW'(i) - rptr)} < count) & (e_word[i] == ld_addr[31:2]));
    end
    assign ld_conflict     = ld_req & hit & !reset;
    assign ld_go           = ld_req & !ld_conflict & !reset;
    assign pop             = !reset & !ld_go & (count != '0);
    assign data_sram_en    = ld_go | pop;
    assign data_sram_wen   = pop ? e_wen[rptr] : 4'b0;
    assign data_sram_addr  = ld_go ? ld_addr : pop ? {e_word[rptr], 2'b00} : 32'b0;
    assign data_sram_wdata = pop ? e_data[rptr] : 32'b0;
    assign sb_count        = count;
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= acc & mis;
            if (push) begin
                e_wen[wptr]  <= a_wen;
                e_word[wptr] <= st_addr[31:2];
                e_data[wptr] <= a_data;
                wptr         <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: directed and randomized checks of mem_store_buffer against a queue model
module tb_mem_store_buffer;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [3:0]  wen;
        logic [29:0] w;
        logic [31:0] d;
    } ent_t;
    logic        clk = 1'b0, reset = 1'b1, st_valid = 1'b0, ld_req = 1'b0;
    logic [2:0]  st_op = 3'b0;
    logic [31:0] st_addr = 32'h0, st_data = 32'h0, ld_addr = 32'h0;
    logic        st_ready, ld_conflict, data_sram_en, misalign;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [2:0]  sb_count;
    int          tests = 0, fails = 0;
    ent_t        q[$];
    mem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_conflict(ld_conflict), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .misalign(misalign), .sb_count(sb_count)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        reset = 1'b1; ld_req = 1'b1; ld_addr = 32'h40; st_valid = 1'b1; st_op = 3'b001; st_addr = 32'h0;
        repeat (2) tick;
        tests++;
        if ({st_ready, ld_conflict, sb_count, data_sram_en, data_sram_wen, misalign} !== {1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b conf=%b cnt=%0d en=%b wen=%b mis=%b", st_ready, ld_conflict, sb_count, data_sram_en, data_sram_wen, misalign);
        end
        reset = 1'b0; st_valid = 1'b0; ld_req = 1'b0;
        tick;
    endtask
    task automatic test_align;
        st_valid = 1'b1; st_op = 3'b100; st_addr = 32'h1003; st_data = 32'h000000AB; ld_req = 1'b0;
        tick;
        st_valid = 1'b0;
        #1;
        tests++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== {1'b1, 4'b1000, 32'h1000, 32'hABABABAB}) begin
            fails++;
            $display("FAIL align_sb: got en=%b wen=%b addr=%h wd=%h want 1 1000 00001000 abababab", data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        tick;
        tests++;
        if (sb_count !== 3'd0) begin fails++; $display("FAIL align_sb_drained: got cnt=%0d want 0", sb_count); end
        st_valid = 1'b1; st_op = 3'b010; st_addr = 32'h2006; st_data = 32'h1234CAFE;
        tick;
        st_valid = 1'b0;
        #1;
        tests++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== {1'b1, 4'b1100, 32'h2004, 32'hCAFECAFE}) begin
            fails++;
            $display("FAIL align_sh: got en=%b wen=%b addr=%h wd=%h want 1 1100 00002004 cafecafe", data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        tick;
        tests++;
        if ({sb_count, data_sram_en} !== {3'd0, 1'b0}) begin fails++; $display("FAIL align_sh_drained: got cnt=%0d en=%b want 0 0", sb_count, data_sram_en); end
    endtask
    task automatic test_full;
        ld_req = 1'b1; ld_addr = 32'h9000; st_op = 3'b001;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'(32'h100 + 4 * i); st_data = 32'(32'hD0 + i);
            tick;
        end
        st_addr = 32'h110; st_data = 32'hEE;
        #1;
        tests++;
        if ({sb_count, st_ready, data_sram_en, data_sram_wen} !== {3'd4, 1'b0, 1'b1, 4'b0}) begin
            fails++;
            $display("FAIL full: got cnt=%0d rdy=%b en=%b wen=%b want 4 0 1 0000", sb_count, st_ready, data_sram_en, data_sram_wen);
        end
        tick;
        st_valid = 1'b0; ld_req = 1'b0;
        #1;
        tests++;
        if (sb_count !== 3'd4) begin fails++; $display("FAIL full_held: got cnt=%0d want 4", sb_count); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== {1'b1, 4'hF, 32'(32'h100 + 4 * i), 32'(32'hD0 + i)}) begin
                fails++;
                $display("FAIL drain_order[%0d]: got en=%b wen=%b addr=%h wd=%h want addr=%h wd=%h", i, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, 32'h100 + 4 * i, 32'hD0 + i);
            end
            tick;
        end
        tests++;
        if ({sb_count, st_ready, data_sram_en} !== {3'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL full_drained: got cnt=%0d rdy=%b en=%b want 0 1 0", sb_count, st_ready, data_sram_en);
        end
    endtask
    task automatic test_conflict;
        ld_req = 1'b1; ld_addr = 32'h7000; st_valid = 1'b1; st_op = 3'b001; st_addr = 32'h3000; st_data = 32'h55;
        tick;
        st_valid = 1'b0; ld_addr = 32'h3002;
        #1;
        tests++;
        if ({ld_conflict, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== {1'b1, 1'b1, 4'hF, 32'h3000, 32'h55}) begin
            fails++;
            $display("FAIL conflict_store: got conf=%b en=%b wen=%b addr=%h wd=%h want 1 1 1111 00003000 00000055", ld_conflict, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        tick;
        tests++;
        if ({ld_conflict, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== {1'b0, 1'b1, 4'h0, 32'h3002, 32'h0}) begin
            fails++;
            $display("FAIL conflict_load: got conf=%b en=%b wen=%b addr=%h wd=%h want 0 1 0000 00003002 0", ld_conflict, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        ld_req = 1'b0;
        tick;
    endtask
    task automatic test_misalign;
        ld_req = 1'b1; ld_addr = 32'h7000; st_valid = 1'b1; st_op = 3'b001; st_addr = 32'h4001;
        #1;
        tests++;
        if (st_ready !== 1'b1) begin fails++; $display("FAIL misalign_accept: got rdy=%b want 1", st_ready); end
        tick;
        st_op = 3'b011; st_addr = 32'h4000;
        #1;
        tests++;
        if ({misalign, sb_count, data_sram_wen} !== {1'b1, 3'd0, 4'h0}) begin
            fails++;
            $display("FAIL misalign_pulse: got mis=%b cnt=%0d wen=%b want 1 0 0000", misalign, sb_count, data_sram_wen);
        end
        tick;
        st_valid = 1'b0;
        #1;
        tests++;
        if ({misalign, sb_count} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL bad_op_silent: got mis=%b cnt=%0d want 0 0", misalign, sb_count);
        end
        ld_req = 1'b0;
        tick;
    endtask
    task automatic test_reset_mid;
        ld_req = 1'b1; ld_addr = 32'h7000; st_op = 3'b001;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'(32'h500 + 4 * i); st_data = 32'(i);
            tick;
        end
        st_valid = 1'b0;
        #1;
        tests++;
        if (sb_count !== 3'd3) begin fails++; $display("FAIL reset_mid_fill: got cnt=%0d want 3", sb_count); end
        reset = 1'b1; ld_req = 1'b0;
        #1;
        tests++;
        if (data_sram_en !== 1'b0) begin fails++; $display("FAIL reset_mid_held: got en=%b want 0", data_sram_en); end
        tick;
        reset = 1'b0;
        #1;
        tests++;
        if ({sb_count, data_sram_en} !== {3'd0, 1'b0}) begin fails++; $display("FAIL reset_mid: got cnt=%0d en=%b want 0 0", sb_count, data_sram_en); end
        for (int i = 0; i < 5; i++) begin
            tick;
            tests++;
            if (data_sram_en !== 1'b0) begin fails++; $display("FAIL reset_mid_nowrite[%0d]: got en=%b wen=%b want en=0", i, data_sram_en, data_sram_wen); end
        end
    endtask
    task automatic test_random(input int n);
        logic        mis_exp, rdy, conf, en, go, acc, bad;
        logic [3:0]  wen;
        logic [31:0] addr, wd;
        ent_t        e;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        q.delete();
        mis_exp = 1'b0;
        for (int c = 0; c < n; c++) begin
            reset    = $urandom_range(0, 99) == 0;
            st_valid = $urandom_range(0, 2) != 0;
            st_op    = $urandom_range(0, 7) == 0 ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
            st_addr  = 32'hA000 + $urandom_range(0, 31);
            st_data  = $urandom;
            ld_req   = $urandom_range(0, 2) == 0;
            ld_addr  = 32'hA000 + $urandom_range(0, 31);
            #1;
            conf = 1'b0;
            foreach (q[k]) if (q[k].w == ld_addr[31:2]) conf = ld_req;
            go = ld_req && !conf;
            rdy = q.size() < DEPTH;
            if (reset) {rdy, conf, go, en, wen, addr, wd} = {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
            else if (go) {en, wen, addr, wd} = {1'b1, 4'h0, ld_addr, 32'h0};
            else if (q.size() > 0) {en, wen, addr, wd} = {1'b1, q[0].wen, q[0].w, 2'b00, q[0].d};
            else {en, wen, addr, wd} = {1'b0, 4'h0, 32'h0, 32'h0};
            tests++;
            if ({st_ready, ld_conflict, sb_count, misalign, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !==
                {rdy, conf, 3'(q.size()), mis_exp, en, wen, addr, wd}) begin
                fails++;
                $display("FAIL random[%0d]: got rdy=%b conf=%b cnt=%0d mis=%b en=%b wen=%b addr=%h wd=%h want %b %b %0d %b %b %b %h %h",
                         c, st_ready, ld_conflict, sb_count, misalign, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                         rdy, conf, q.size(), mis_exp, en, wen, addr, wd);
            end
            if (reset) begin
                q.delete();
                mis_exp = 1'b0;
            end else begin
                acc = st_valid && rdy;
                if (!go && q.size() > 0) void'(q.pop_front());
                mis_exp = acc && ((st_op == 3'b010 && st_addr[0]) || (st_op == 3'b001 && st_addr[1:0] != 2'b00));
                bad = !(st_op == 3'b001 || st_op == 3'b010 || st_op == 3'b100);
                if (acc && !mis_exp && !bad) begin
                    e.w = st_addr[31:2];
                    if (st_op == 3'b001) begin e.wen = 4'hF; e.d = st_data; end
                    else if (st_op == 3'b010) begin e.wen = st_addr[1] ? 4'b1100 : 4'b0011; e.d = {2{st_data[15:0]}}; end
                    else begin e.wen = 4'b0001 << st_addr[1:0]; e.d = {4{st_data[7:0]}}; end
                    q.push_back(e);
                end
            end
            tick;
        end
        reset = 1'b0; st_valid = 1'b0; ld_req = 1'b0;
        tick;
    endtask
    initial begin
        tick;
        test_reset;
        test_align;
        test_full;
        test_conflict;
        test_misalign;
        test_reset_mid;
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_store_buffer.md
MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of store-buffer entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 st_valid  input  1  store request from EX stage is valid this cycle.
REQ-005 st_ready  output  1  buffer accepts the store this cycle.
REQ-006 st_op  input  3  one-hot store type: bit0 sw, bit1 sh, bit2 sb.
REQ-007 st_addr  input  32  byte address of the store.
REQ-008 st_data  input  32  register data; the low byte or halfword is used for sb/sh.
REQ-009 ld_req  input  1  a load needs the data-SRAM port this cycle.
REQ-010 ld_addr  input  32  load byte address.
REQ-011 ld_conflict  output  1  a buffered store overlaps the load word; the pipeline must stall the load.
REQ-012 data_sram_en / data_sram_wen / data_sram_addr / data_sram_wdata  output  1/4/32/32  data-SRAM port.
REQ-013 misalign  output  1  one-cycle pulse: the accepted store was misaligned and dropped.
REQ-014 sb_count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-015 The FIFO SHALL use rptr and wptr (log2(DEPTH) bits, wrapping modulo DEPTH) and count; full is count==DEPTH and empty is count==0.
REQ-016 st_ready SHALL equal !full, with no same-cycle bypass when full.
REQ-017 A push SHALL occur when st_valid && st_ready; it stores {wen, word address, aligned wdata} at wptr, and wptr increments.
REQ-018 sw alignment: wen=4'b1111, wdata=st_data.
REQ-019 sh alignment: wen is 4'b1100 if st_addr[1] else 4'b0011, and wdata={2{st_data[15:0]}}.
REQ-020 sb alignment: wen=4'b0001<<st_addr[1:0], wdata={4{st_data[7:0]}}.
REQ-021 Misalignment handling:
- Misaligned cases are sh with st_addr[0]=1, or sw with st_addr[1:0]!=0.
- Such a store SHALL still be accepted, SHALL NOT be pushed, and misalign SHALL be 1 in the next cycle.
REQ-022 An st_op that is not one-hot SHALL be accepted and dropped silently, with no push and no misalign.
REQ-023 ld_conflict SHALL be combinational: ld_req && some occupied entry has word address == ld_addr[31:2].
REQ-024 Port arbitration SHALL be combinational, every cycle:
- (a) ld_req && !ld_conflict: load owns the port; en=1, wen=0, addr=ld_addr, wdata=0.
- (b) otherwise, if not empty: head store owns the port; en=1, wen=entry wen, addr={word addr,2'b00}, wdata=entry data.
- (c) otherwise: en=0, wen=0, addr=0, wdata=0.
REQ-025 The SRAM write SHALL complete in the issuing cycle; in case (b) the entry pops at the clock edge and rptr increments.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; pointer wrap SHALL be transparent.
REQ-027 Entries SHALL drain strictly in acceptance order; a later store SHALL never be written before an earlier one.
REQ-028 sb_count SHALL equal count, registered.
REQ-029 Under a sustained conflicting load, the store head SHALL issue each cycle until no overlapping entry remains; the load then proceeds.

Reset
REQ-030 On reset: rptr=wptr=count=0 and misalign=0.
REQ-031 With reset held: st_ready=1, ld_conflict=0, sb_count=0, data_sram_en=0, wen=0.
REQ-032 Entry contents SHALL NOT need reset; reset mid-drain SHALL discard all pending stores with no further SRAM writes.

Verification
REQ-033 Alignment: sb at 0x1003 with data 0x000000AB, ld_req=0.
- Next cycle: en=1, wen=4'b1000, addr=0x1000, wdata=0xABABABAB.
- The cycle after: sb_count=0.
REQ-034 Alignment: sh at 0x2006 with data 0x1234CAFE drains with wen=4'b1100, addr=0x2004, wdata=0xCAFECAFE.
REQ-035 Load priority and full:
- Push 4 sw with ld_req=1 on distinct words: sb_count=4, st_ready=0, and a 5th store is held.
- Drop ld_req: stores drain over 4 cycles in order, then st_ready=1.
REQ-036 Conflict: buffer a sw to 0x3000, then ld_req=1 with ld_addr=0x3002.
- ld_conflict=1 and the port issues the store (wen=4'b1111).
- Next cycle: ld_conflict=0 and the port issues the load (wen=0, addr=0x3002).
REQ-037 Misaligned: sw at 0x4001 is accepted; next cycle misalign=1, sb_count unchanged, no SRAM write.
REQ-038 Reset mid-operation: assert reset with 3 entries pending; next cycle sb_count=0, en=0, and no pending store is ever written.
